// File: rtl/calc_key_sequencer.sv
// Keypad-to-control sequencer for the calculator datapath.
// It handles operand entry, add/subtract sequencing through the ALU handshake, and memory store/recall.
//
// state   | meaning
// A_FIRST | waiting for the first digit of operand A
// A_ENTRY | appending digits to operand A
// B_FIRST | operator latched, waiting for the first digit of operand B
// B_ENTRY | appending digits to operand B
// WAIT    | ALU busy, keypad blocked until alu_done
// RESULT  | result on display
// MEM_ST  | store prefix seen, waiting for the slot digit
// MEM_RD  | recall prefix seen, waiting for the slot digit
module calc_key_sequencer #(
    parameter int MAX_DIGITS = 4,
    parameter int MEM_SLOTS  = 4,
    parameter int SLOT_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              alu_done,
    input  logic              alu_ovf,
    output logic              key_ready,
    output logic              digit_we,
    output logic [3:0]        digit_val,
    output logic              entry_clr,
    output logic              opnd_sel,
    output logic              op_sub,
    output logic              alu_start,
    output logic              res_to_a,
    output logic              mem_we,
    output logic              mem_re,
    output logic [SLOT_W-1:0] mem_slot,
    output logic [1:0]        disp_sel,
    output logic              err
);

    typedef enum logic [2:0] {
        A_FIRST, A_ENTRY, B_FIRST, B_ENTRY, WAIT, RESULT, MEM_ST, MEM_RD
    } state_t;

    localparam logic [3:0] K_CLR   = 4'hA;
    localparam logic [3:0] K_ADD   = 4'hB;
    localparam logic [3:0] K_SUB   = 4'hC;
    localparam logic [3:0] K_EQ    = 4'hD;
    localparam logic [3:0] K_RCL   = 4'hE;
    localparam logic [3:0] K_STO   = 4'hF;
    localparam logic [3:0] CNT_MAX = 4'(MAX_DIGITS);

    state_t              state, nx_state, ret_state, nx_ret;
    logic [3:0]          cnt, nx_cnt;
    logic                chain, nx_chain, pend_sub, nx_pend;
    logic                nx_key_ready, nx_digit_we, nx_entry_clr, nx_opnd_sel, nx_op_sub;
    logic                nx_alu_start, nx_res_to_a, nx_mem_we, nx_mem_re, nx_err;
    logic [3:0]          nx_digit_val;
    logic [SLOT_W-1:0]   nx_mem_slot;
    logic [1:0]          nx_disp_sel;

    logic key_acc, act, is_digit, is_op, is_pfx, slot_ok;

    assign key_acc  = key_valid & key_ready;
    // Once err is set, only the clear key does anything.
    assign act      = key_acc & ~err;
    assign is_digit = (key_code <= 4'd9);
    assign is_op    = (key_code == K_ADD) || (key_code == K_SUB);
    assign is_pfx   = (key_code == K_STO) || (key_code == K_RCL);
    assign slot_ok  = 32'(key_code) < MEM_SLOTS;

    always_comb begin
        nx_state     = state;
        nx_ret       = ret_state;
        nx_cnt       = cnt;
        nx_chain     = chain;
        nx_pend      = pend_sub;
        nx_digit_we  = 1'b0;
        nx_entry_clr = 1'b0;
        nx_alu_start = 1'b0;
        nx_res_to_a  = 1'b0;
        nx_mem_we    = 1'b0;
        nx_mem_re    = 1'b0;
        nx_digit_val = digit_val;
        nx_opnd_sel  = opnd_sel;
        nx_op_sub    = op_sub;
        nx_mem_slot  = mem_slot;
        nx_disp_sel  = disp_sel;
        nx_err       = err;

        if (key_acc && key_code == K_CLR) begin
            nx_entry_clr = 1'b1;
            nx_opnd_sel  = 1'b0;
            nx_op_sub    = 1'b0;
            nx_err       = 1'b0;
            nx_cnt       = 4'd0;
            nx_chain     = 1'b0;
            nx_disp_sel  = 2'b00;
            nx_state     = A_FIRST;
        end else begin
            case (state)
                A_FIRST, A_ENTRY: if (act) begin
                    if (is_digit) begin
                        if (state == A_FIRST) begin
                            nx_entry_clr = 1'b1;
                            nx_digit_we  = 1'b1;
                            nx_digit_val = key_code;
                            nx_cnt       = 4'd1;
                            nx_state     = A_ENTRY;
                        end else if (cnt < CNT_MAX) begin
                            nx_digit_we  = 1'b1;
                            nx_digit_val = key_code;
                            nx_cnt       = cnt + 4'd1;
                        end
                    end else if (is_op) begin
                        nx_op_sub = (key_code == K_SUB);
                        nx_cnt    = 4'd0;
                        nx_state  = B_FIRST;
                    end else if (is_pfx) begin
                        nx_ret   = state;
                        nx_state = (key_code == K_STO) ? MEM_ST : MEM_RD;
                    end
                end
                B_FIRST: if (act) begin
                    if (is_digit) begin
                        nx_opnd_sel  = 1'b1;
                        nx_disp_sel  = 2'b01;
                        nx_entry_clr = 1'b1;
                        nx_digit_we  = 1'b1;
                        nx_digit_val = key_code;
                        nx_cnt       = 4'd1;
                        nx_state     = B_ENTRY;
                    end else if (is_op) begin
                        nx_op_sub = (key_code == K_SUB);
                    end else if (is_pfx) begin
                        nx_ret   = state;
                        nx_state = (key_code == K_STO) ? MEM_ST : MEM_RD;
                    end
                end
                B_ENTRY: if (act) begin
                    if (is_digit) begin
                        if (cnt < CNT_MAX) begin
                            nx_digit_we  = 1'b1;
                            nx_digit_val = key_code;
                            nx_cnt       = cnt + 4'd1;
                        end
                    end else if (key_code == K_EQ) begin
                        nx_alu_start = 1'b1;
                        nx_chain     = 1'b0;
                        nx_state     = WAIT;
                    end else if (is_op) begin
                        // Chained operator: the new op applies after the result moves to A.
                        nx_alu_start = 1'b1;
                        nx_chain     = 1'b1;
                        nx_pend      = (key_code == K_SUB);
                        nx_state     = WAIT;
                    end else if (is_pfx) begin
                        nx_ret   = state;
                        nx_state = (key_code == K_STO) ? MEM_ST : MEM_RD;
                    end
                end
                WAIT: if (alu_done) begin
                    if (alu_ovf) begin
                        nx_err      = 1'b1;
                        nx_disp_sel = 2'b10;
                        nx_chain    = 1'b0;
                        nx_state    = RESULT;
                    end else if (chain) begin
                        nx_res_to_a = 1'b1;
                        nx_op_sub   = pend_sub;
                        nx_opnd_sel = 1'b0;
                        nx_disp_sel = 2'b00;
                        nx_cnt      = 4'd0;
                        nx_chain    = 1'b0;
                        nx_state    = B_FIRST;
                    end else begin
                        nx_disp_sel = 2'b10;
                        nx_state    = RESULT;
                    end
                end
                RESULT: if (act) begin
                    if (is_digit) begin
                        nx_opnd_sel  = 1'b0;
                        nx_disp_sel  = 2'b00;
                        nx_entry_clr = 1'b1;
                        nx_digit_we  = 1'b1;
                        nx_digit_val = key_code;
                        nx_cnt       = 4'd1;
                        nx_state     = A_ENTRY;
                    end else if (is_op) begin
                        nx_res_to_a = 1'b1;
                        nx_op_sub   = (key_code == K_SUB);
                        nx_cnt      = 4'd0;
                        nx_state    = B_FIRST;
                    end else if (is_pfx) begin
                        nx_ret   = state;
                        nx_state = (key_code == K_STO) ? MEM_ST : MEM_RD;
                    end
                end
                MEM_ST, MEM_RD: if (act) begin
                    nx_state = ret_state;
                    if (is_digit && !slot_ok) begin
                        nx_err = 1'b1;
                    end else if (is_digit) begin
                        nx_mem_slot = SLOT_W'(key_code);
                        if (state == MEM_ST) begin
                            nx_mem_we = 1'b1;
                        end else begin
                            // A recalled value is a complete operand, so further digits are refused.
                            nx_mem_re = 1'b1;
                            nx_cnt    = CNT_MAX;
                            case (ret_state)
                                A_FIRST, A_ENTRY: nx_state = A_ENTRY;
                                B_FIRST, B_ENTRY: begin
                                    nx_opnd_sel = 1'b1;
                                    nx_state    = B_ENTRY;
                                end
                                RESULT: begin
                                    nx_opnd_sel = 1'b0;
                                    nx_disp_sel = 2'b00;
                                    nx_state    = A_ENTRY;
                                end
                                default: nx_state = A_FIRST;
                            endcase
                        end
                    end
                end
                default: nx_state = A_FIRST;
            endcase
        end

        nx_key_ready = (nx_state != WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= A_FIRST;
            ret_state <= A_FIRST;
            cnt       <= 4'd0;
            chain     <= 1'b0;
            pend_sub  <= 1'b0;
            key_ready <= 1'b1;
            digit_we  <= 1'b0;
            digit_val <= 4'd0;
            entry_clr <= 1'b0;
            opnd_sel  <= 1'b0;
            op_sub    <= 1'b0;
            alu_start <= 1'b0;
            res_to_a  <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_slot  <= '0;
            disp_sel  <= 2'b00;
            err       <= 1'b0;
        end else begin
            state     <= nx_state;
            ret_state <= nx_ret;
            cnt       <= nx_cnt;
            chain     <= nx_chain;
            pend_sub  <= nx_pend;
            key_ready <= nx_key_ready;
            digit_we  <= nx_digit_we;
            digit_val <= nx_digit_val;
            entry_clr <= nx_entry_clr;
            opnd_sel  <= nx_opnd_sel;
            op_sub    <= nx_op_sub;
            alu_start <= nx_alu_start;
            res_to_a  <= nx_res_to_a;
            mem_we    <= nx_mem_we;
            mem_re    <= nx_mem_re;
            mem_slot  <= nx_mem_slot;
            disp_sel  <= nx_disp_sel;
            err       <= nx_err;
        end
    end

endmodule
